id_ex_pipe_buffer: RTL

Parametrised, elastic successor to the ID→EXE pipeline register. It carries an arbitrary-width decoded-instruction payload between pipeline stages through a DEPTH-entry buffer with a valid/ready handshake on each side. It supports a synchronous flush for branch squashing, and replaces the fixed freeze/flush register with backpressure-aware buffering. It sits between the ID stage and the EXE stage, and is reusable at any other stage boundary.

---
 rtl/id_ex_pipe_buffer.sv | 69 ++++++
 1 files changed

// File: rtl/id_ex_pipe_buffer.sv
// Elastic ID->EXE pipeline buffer: DEPTH-entry circular FIFO with valid/ready on both sides
// and a synchronous flush for branch squashing.
module id_ex_pipe_buffer #(
    parameter int DATA_W = 150,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic              push;
    logic              pop;

    // Ready comes from registered occupancy only, so full + out_ready never lets a beat through.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // A bubble must present all-zero payload so no stray stage enables leak downstream.
    assign out_data  = out_valid ? mem[rp] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wp    <= '0;
            rp    <= '0;
        end else if (flush) begin
            count <= '0;
            wp    <= '0;
            rp    <= '0;
        end else begin
            if (push) begin
                wp <= (wp == LAST_IDX) ? '0 : wp + PTR_W'(1);
            end
            if (pop) begin
                rp <= (rp == LAST_IDX) ? '0 : rp + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Payload storage is deliberately left out of reset and flush.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= in_data;
        end
    end

endmodule
